// File: rtl/chirp_sweep_gen_if.sv
// Config, control and output bundle of the chirp sweep generator.
// The master side drives config and control; the slave side is the generator.
interface chirp_sweep_gen_if #(
  parameter int FREQ_W = 16,
  parameter int OUT_W  = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [FREQ_W-1:0] cfg_f_lo;
  logic [FREQ_W-1:0] cfg_f_hi;
  logic [FREQ_W-1:0] cfg_f_step;
  logic [1:0]        cfg_mode;
  logic              cfg_repeat;
  logic              cfg_wave;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic              wrap;
  logic [FREQ_W-1:0] freq_out;
  logic [OUT_W-1:0]  wave_out;
  logic              sq_out;

  modport master (
    output cfg_valid, cfg_f_lo, cfg_f_hi, cfg_f_step, cfg_mode, cfg_repeat, cfg_wave,
    output start, stop,
    input  cfg_ready, busy, done, wrap, freq_out, wave_out, sq_out
  );

  modport slave (
    input  cfg_valid, cfg_f_lo, cfg_f_hi, cfg_f_step, cfg_mode, cfg_repeat, cfg_wave,
    input  start, stop,
    output cfg_ready, busy, done, wrap, freq_out, wave_out, sq_out
  );
endinterface

// File: rtl/chirp_sweep_gen.sv
// Linear-FM sweep generator: a frequency register steps between programmable
// bounds and drives a phase accumulator producing saw/triangle/square outputs.
module chirp_sweep_gen #(
  parameter int FREQ_W   = 16,
  parameter int PHASE_W  = 24,
  parameter int OUT_W    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  chirp_sweep_gen_if.slave bus
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [FREQ_W-1:0]  FREQ_ZERO = {FREQ_W{1'b0}};
  localparam logic [PHASE_W-1:0] PH_ZERO   = {PHASE_W{1'b0}};
  localparam logic [1:0]         MODE_DOWN = 2'b01;
  localparam logic [1:0]         MODE_TRI  = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [FREQ_W-1:0]  lo_q, lo_d, hi_q, hi_d, step_q, step_d;
  logic [1:0]         mode_q, mode_d;
  logic               rep_q, rep_d, wsel_q, wsel_d, dir_q, dir_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               ready_q, ready_d, busy_q, busy_d;
  logic               done_q, done_d, wrap_q, wrap_d;
  logic [OUT_W-1:0]   wave_q, wave_d;
  logic               sq_q, sq_d;
  logic               cfg_hs;
  logic [FREQ_W-1:0]  hi_eff, hi_eff_new, sweep_end;

  // Increment with the (FREQ_W+1)-bit sum saturating at the upper limit.
  function automatic logic [FREQ_W-1:0] up_clamp(input logic [FREQ_W-1:0] base,
                                                 input logic [FREQ_W-1:0] inc,
                                                 input logic [FREQ_W-1:0] lim);
    logic [FREQ_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum > {1'b0, lim}) return lim;
    else return sum[FREQ_W-1:0];
  endfunction

  function automatic logic [FREQ_W-1:0] dn_clamp(input logic [FREQ_W-1:0] base,
                                                 input logic [FREQ_W-1:0] dec,
                                                 input logic [FREQ_W-1:0] lim);
    logic [FREQ_W:0] diff;
    diff = {1'b0, base} - {1'b0, dec};
    if (diff[FREQ_W] || (diff[FREQ_W-1:0] < lim)) return lim;
    else return diff[FREQ_W-1:0];
  endfunction

  // Triangle folds the upper half of the phase cycle by inverting the lower slice.
  function automatic logic [OUT_W-1:0] wave_fn(input logic [PHASE_W-1:0] ph,
                                               input logic tri_sel);
    logic [OUT_W-1:0] smp;
    if (tri_sel) begin
      smp = ph[PHASE_W-2 -: OUT_W];
      if (ph[PHASE_W-1]) smp = ~smp;
      else smp = smp;
    end else begin
      smp = ph[PHASE_W-1 -: OUT_W];
    end
    return smp;
  endfunction

  assign bus.cfg_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
  assign bus.freq_out  = freq_q;
  assign bus.wave_out  = wave_q;
  assign bus.sq_out    = sq_q;

  // Next-state: config capture, sweep sequencing and phase accumulation.
  always_comb begin
    cfg_hs     = (state_q == S_IDLE) && bus.cfg_valid;
    lo_d       = cfg_hs ? bus.cfg_f_lo   : lo_q;
    hi_d       = cfg_hs ? bus.cfg_f_hi   : hi_q;
    step_d     = cfg_hs ? bus.cfg_f_step : step_q;
    mode_d     = cfg_hs ? bus.cfg_mode   : mode_q;
    rep_d      = cfg_hs ? bus.cfg_repeat : rep_q;
    wsel_d     = cfg_hs ? bus.cfg_wave   : wsel_q;
    hi_eff     = (hi_q > lo_q) ? hi_q : lo_q;
    hi_eff_new = (hi_d > lo_d) ? hi_d : lo_d;
    sweep_end  = dir_q ? lo_q : hi_eff;
    state_d    = state_q;
    dir_d      = dir_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    div_d      = div_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        phase_d = PH_ZERO;
        freq_d  = FREQ_ZERO;
        div_d   = DIV_ZERO;
        if (bus.start && !bus.stop) begin
          state_d = S_ACTIVE;
          dir_d   = (mode_d == MODE_DOWN);
          freq_d  = (mode_d == MODE_DOWN) ? hi_eff_new : lo_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        phase_d = phase_q + PHASE_W'(freq_q);
        if (bus.stop) begin
          state_d = S_IDLE;
          phase_d = PH_ZERO;
          freq_d  = FREQ_ZERO;
          div_d   = DIV_ZERO;
        end else if (div_q == DIV_LAST) begin
          div_d = DIV_ZERO;
          if (freq_q != sweep_end) begin
            freq_d = dir_q ? dn_clamp(freq_q, step_q, lo_q) : up_clamp(freq_q, step_q, hi_eff);
          end else if ((mode_q == MODE_TRI) && !dir_q) begin
            dir_d  = 1'b1;
            freq_d = dn_clamp(hi_eff, step_q, lo_q);
          end else if (rep_q) begin
            wrap_d = 1'b1;
            if (mode_q == MODE_TRI) begin
              dir_d  = 1'b0;
              freq_d = up_clamp(lo_q, step_q, hi_eff);
            end else begin
              freq_d = (mode_q == MODE_DOWN) ? hi_eff : lo_q;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            phase_d = PH_ZERO;
            freq_d  = FREQ_ZERO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = PH_ZERO;
        freq_d  = FREQ_ZERO;
        div_d   = DIV_ZERO;
      end
    endcase

    busy_d  = (state_d == S_ACTIVE);
    ready_d = (state_d == S_IDLE);
    wave_d  = wave_fn(phase_d, wsel_d);
    sq_d    = phase_d[PHASE_W-1];
  end

  // State, config and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= FREQ_ZERO;
      hi_q    <= FREQ_ZERO;
      step_q  <= FREQ_ZERO;
      mode_q  <= 2'b00;
      rep_q   <= 1'b0;
      wsel_q  <= 1'b0;
      dir_q   <= 1'b0;
      freq_q  <= FREQ_ZERO;
      phase_q <= PH_ZERO;
      div_q   <= DIV_ZERO;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      wave_q  <= {OUT_W{1'b0}};
      sq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      rep_q   <= rep_d;
      wsel_q  <= wsel_d;
      dir_q   <= dir_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      wave_q  <= wave_d;
      sq_q    <= sq_d;
    end
  end

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Bench for chirp_sweep_gen: directed scenarios with literal expectations plus
// randomized sweeps, all compared each cycle against a level-list sweep model.
module tb_chirp_sweep_gen;
  localparam int FREQ_W   = 16;
  localparam int PHASE_W  = 24;
  localparam int OUT_W    = 8;
  localparam int STEP_DIV = 4;
  localparam int LEG_CAP  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chirp_sweep_gen_if #(.FREQ_W(FREQ_W), .OUT_W(OUT_W)) bus ();

  chirp_sweep_gen #(
    .FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: a sweep is a list of frequency levels, each held STEP_DIV cycles.
  int  m_lo, m_hi, m_step, m_mode, m_rep, m_wave;
  int  m_phase, m_idx, m_hold;
  bit  m_active, m_done, m_wrap;
  bit  m_ok = 1'b0;
  int  pass_q[$];

  function automatic void add_leg(input int from, input int to, input int step);
    int v = from;
    int n = 0;
    pass_q.push_back(v);
    while (v != to && n < LEG_CAP) begin
      if (to > v) v = (v + step > to) ? to : v + step;
      else        v = (v - step < to) ? to : v - step;
      pass_q.push_back(v);
      n++;
    end
  endfunction

  function automatic void build_pass(input bit first);
    int he = (m_hi > m_lo) ? m_hi : m_lo;
    pass_q.delete();
    if (m_mode == 1) begin
      add_leg(he, m_lo, m_step);
    end else if (m_mode == 2) begin
      if (first) add_leg(m_lo, he, m_step);
      else       add_leg((m_lo + m_step > he) ? he : m_lo + m_step, he, m_step);
      add_leg((he - m_step < m_lo) ? m_lo : he - m_step, m_lo, m_step);
    end else begin
      add_leg(m_lo, he, m_step);
    end
  endfunction

  function automatic int exp_wave(input int ph, input int w);
    int t;
    if (w == 0) begin
      t = (ph >> 16) & 255;
    end else begin
      t = (ph >> 15) & 255;
      if (ph >= (1 << 23)) t = 255 - t;
    end
    return t;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_lo = 0; m_hi = 0; m_step = 0; m_mode = 0; m_rep = 0; m_wave = 0;
      m_active = 1'b0; m_phase = 0; m_idx = 0; m_hold = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (!m_active && bus.cfg_valid) begin
        m_lo = bus.cfg_f_lo; m_hi = bus.cfg_f_hi; m_step = bus.cfg_f_step;
        m_mode = bus.cfg_mode; m_rep = bus.cfg_repeat; m_wave = bus.cfg_wave;
      end
      if (!m_active) begin
        if (bus.start && !bus.stop) begin
          build_pass(1'b1);
          m_active = 1'b1; m_idx = 0; m_hold = 0; m_phase = 0;
        end
      end else begin
        m_phase = (m_phase + pass_q[m_idx]) % (1 << PHASE_W);
        if (bus.stop) begin
          m_active = 1'b0; m_phase = 0;
        end else begin
          m_hold++;
          if (m_hold == STEP_DIV) begin
            m_hold = 0;
            m_idx++;
            if (m_idx == pass_q.size()) begin
              if (m_rep != 0) begin
                build_pass(1'b0); m_idx = 0; m_wrap = 1'b1;
              end else begin
                m_active = 1'b0; m_phase = 0; m_done = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  int        e_freq;
  bit [28:0] act_v, exp_v;
  always @(negedge clk) begin
    if (m_ok) begin
      e_freq = m_active ? pass_q[m_idx] : 0;
      act_v = {bus.cfg_ready, bus.busy, bus.done, bus.wrap, bus.sq_out, bus.wave_out, bus.freq_out};
      exp_v = {!m_active, m_active, m_done, m_wrap, (m_phase >= (1 << 23)),
               8'(exp_wave(m_phase, m_wave)), 16'(e_freq)};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t {rdy,busy,done,wrap,sq,wave,freq} got %h expected %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int lo, input int hi, input int st,
                         input int md, input int rp, input int wv);
    bus.cfg_valid  = 1'b1;
    bus.cfg_f_lo   = lo[15:0];
    bus.cfg_f_hi   = hi[15:0];
    bus.cfg_f_step = st[15:0];
    bus.cfg_mode   = md[1:0];
    bus.cfg_repeat = rp[0];
    bus.cfg_wave   = wv[0];
  endtask

  task automatic launch(input int lo, input int hi, input int st,
                        input int md, input int rp, input int wv);
    @(negedge clk);
    set_cfg(lo, hi, st, md, rp, wv);
    bus.start = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic stop_sweep();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  int t1[4]  = '{100, 104, 108, 110};
  int t2[10] = '{10, 15, 20, 15, 10, 15, 20, 15, 10, 15};
  int t5[3]  = '{1000, 700, 400};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_f_lo = '0; bus.cfg_f_hi = '0; bus.cfg_f_step = '0;
    bus.cfg_mode = 2'b00; bus.cfg_repeat = 1'b0; bus.cfg_wave = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_freq", bus.freq_out, 0);
    chk("rst_wave", bus.wave_out, 0);
    rst = 1'b0;

    // 1: up one-shot
    launch(100, 110, 4, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t1_freq", bus.freq_out, t1[i/4]);
      @(negedge clk);
    end
    chk("t1_done", bus.done, 1);
    chk("t1_busy_fall", bus.busy, 0);
    chk("t1_freq_idle", bus.freq_out, 0);
    @(negedge clk);
    chk("t1_done_pulse", bus.done, 0);

    // 2: triangle repeat
    launch(10, 20, 5, 2, 1, 1);
    for (int s = 0; s < 40; s++) begin
      if (s % 4 == 0) chk("t2_freq", bus.freq_out, t2[s/4]);
      if (s == 4)  chk("t2_nowrap_first", bus.wrap, 0);
      if (s == 20) chk("t2_wrap", bus.wrap, 1);
      @(negedge clk);
    end
    stop_sweep();
    chk("t2_stop_busy", bus.busy, 0);
    chk("t2_stop_done", bus.done, 0);

    // 3: constant tone, repeat
    launch(16'h4000, 16'h4000, 0, 0, 1, 0);
    for (int s = 0; s < 521; s++) begin
      if (s == 4 || s == 8) chk("t3_wrap", bus.wrap, 1);
      if (s == 5)   chk("t3_wrap_pulse", bus.wrap, 0);
      if (s == 8)   chk("t3_wave8", bus.wave_out, 2);
      if (s == 100) chk("t3_wave100", bus.wave_out, 25);
      if (s == 300) chk("t3_freq", bus.freq_out, 16'h4000);
      if (s == 511) chk("t3_sq511", bus.sq_out, 0);
      if (s == 512) chk("t3_sq512", bus.sq_out, 1);
      @(negedge clk);
    end
    stop_sweep();

    // 4: down one-shot with hi below lo
    launch(50, 40, 3, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("t4_freq", bus.freq_out, 50);
    @(negedge clk);
    chk("t4_done", bus.done, 1);
    chk("t4_busy", bus.busy, 0);

    // 5: config offered while busy, then stop
    launch(0, 1000, 300, 1, 0, 0);
    for (int s = 0; s < 10; s++) begin
      if (s % 4 == 0) chk("t5_freq", bus.freq_out, t5[s/4]);
      if (s == 5) set_cfg(5, 6, 7, 0, 1, 1);
      if (s == 7) chk("t5_ready_busy", bus.cfg_ready, 0);
      if (s == 9) begin bus.cfg_valid = 1'b0; bus.stop = 1'b1; end
      @(negedge clk);
    end
    bus.stop = 1'b0;
    chk("t5_stop_busy", bus.busy, 0);
    chk("t5_stop_done", bus.done, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_old_cfg", bus.freq_out, 1000);
    stop_sweep();

    // 6: reset mid triangle sweep, then start with zeroed config
    launch(10, 20, 5, 2, 1, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_ready", bus.cfg_ready, 1);
    chk("t6_freq", bus.freq_out, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t6_busy_run", bus.busy, 1);
    repeat (4) @(negedge clk);
    chk("t6_done", bus.done, 1);

    // Randomized sweeps
    for (int it = 0; it < 40; it++) begin
      int lo, hi, span, st, n;
      lo = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
      hi = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
      span = (hi > lo) ? hi - lo : lo - hi;
      st = span / $urandom_range(1, 12) + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) st = 0;
      if (st > 65535) st = 65535;
      @(negedge clk);
      set_cfg(lo, hi, st, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        bus.cfg_valid = 1'b0;
      end
      bus.start = 1'b1;
      bus.stop  = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
      n = $urandom_range(10, 300);
      for (int c = 0; c < n; c++) begin
        bus.cfg_valid = ($urandom_range(0, 15) == 0);
        bus.cfg_f_lo   = 16'($urandom_range(0, 65535));
        bus.cfg_f_hi   = 16'($urandom_range(0, 65535));
        bus.cfg_f_step = 16'($urandom_range(0, 65535));
        bus.cfg_mode   = 2'($urandom_range(0, 3));
        bus.start = bus.busy && ($urandom_range(0, 7) == 0);
        bus.stop  = ($urandom_range(0, 99) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        @(negedge clk);
      end
      bus.cfg_valid = 1'b0; bus.start = 1'b0; rst = 1'b0;
      stop_sweep();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
